traffic_phase_arbiter: RTL

Sequencer and arbiter for the four-approach intersection lights: main road 1 (m1), main road 2 (m2), main turn (mt) and side road (s), plus a pedestrian walk phase.
- Main road is the default resting phase.
- Turn, side and pedestrian requests are latched and granted round-robin.
- Every handover goes through timed yellow and all-red clearance.
- Drives the same 3-bit lamp buses as the existing fixed-cycle traffic light controller, and replaces its fixed schedule with demand-driven scheduling.

---
 rtl/traffic_pkg.sv | 54 +++++
 rtl/traffic_phase_arbiter_phase_timer.sv | 23 ++
 rtl/traffic_phase_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase/state enums and round-robin helpers for the
// intersection phase arbiter.
package traffic_pkg;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  typedef enum logic [1:0] {
    MAIN = 2'd0,
    TURN = 2'd1,
    SIDE = 2'd2,
    PED  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    GREEN_S  = 2'd0,
    YELLOW_S = 2'd1,
    ALLRED_S = 2'd2
  } state_t;

  // Lamps that are green in a phase, bit order {m1, m2, mt, s}.
  function automatic logic [3:0] green_set(phase_t p);
    case (p)
      MAIN:    return 4'b1100;
      TURN:    return 4'b1010;
      SIDE:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Round-robin successor among the demand phases: TURN -> SIDE -> PED -> TURN.
  function automatic phase_t rr_next(phase_t p);
    case (p)
      TURN:    return SIDE;
      SIDE:    return PED;
      default: return TURN;
    endcase
  endfunction

  // First pending demand phase at or after ptr; MAIN when nothing is pending.
  function automatic phase_t rr_pick(logic [3:1] pend, phase_t ptr);
    phase_t cand;
    phase_t pick;
    cand = ptr;
    pick = MAIN;
    for (int k = 0; k < 3; k++) begin
      if (pick == MAIN && pend[cand]) pick = cand;
      cand = rr_next(cand);
    end
    return pick;
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_phase_timer.sv
// Saturating up-counter with synchronous clear and a >= threshold compare,
// shared by every state of the phase sequencer.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] count,
  output logic             ge
);

  // Count cycles in the current state; clear on entry, hold at all-ones.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (clr)                count <= '0;
    else if (count != '1)   count <= count + CNT_W'(1);
  end

  assign ge = (count >= n);

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Demand-driven phase sequencer: MAIN rests green, TURN/SIDE/PED demands are
// latched and granted round-robin, every handover passes yellow and all-red.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_turn,
  input  logic       req_side,
  input  logic       req_ped,
  output logic [2:0] m1,
  output logic [2:0] m2,
  output logic [2:0] mt,
  output logic [2:0] s,
  output logic       walk,
  output logic [1:0] phase,
  output logic       ped_ack
);

  // Timer compares are "count >= length-1" so a state lasts exactly length cycles.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  phase_t     next_q, next_d;
  phase_t     ptr_q, ptr_d;
  logic [3:1] pend_q, pend_d;
  logic [3:1] req;

  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] count;
  logic             ge;
  logic             timer_clr;

  assign req = {req_ped, req_side, req_turn};

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .clr   (timer_clr),
    .n     (thresh),
    .count (count),
    .ge    (ge)
  );

  // Pick the length the current state must reach; a held TURN/SIDE request
  // stretches the green up to MAX_GREEN, dropping it falls back to MIN_GREEN.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    thresh = MIN_LAST;
    case (state_q)
      GREEN_S: begin
        if ((phase_q == TURN && req_turn) || (phase_q == SIDE && req_side))
          thresh = MAX_LAST;
      end
      YELLOW_S: thresh = YEL_LAST;
      ALLRED_S: thresh = AR_LAST;
      default:  thresh = MIN_LAST;
    endcase
  end

  // Next-state, grant and pending-demand logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    next_d  = next_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;

    case (state_q)
      GREEN_S: begin
        if (phase_q == MAIN) begin
          if (ge && (|pend_q)) begin
            state_d = YELLOW_S;
            next_d  = rr_pick(pend_q, ptr_q);
            ptr_d   = rr_next(next_d);
          end
        end else if (ge) begin
          state_d = YELLOW_S;
          next_d  = MAIN;
        end
      end
      YELLOW_S: if (ge) state_d = ALLRED_S;
      ALLRED_S: begin
        if (ge) begin
          state_d = GREEN_S;
          phase_d = next_q;
        end
      end
      default: state_d = GREEN_S;
    endcase

    // A demand is served when its phase enters green; while that phase is
    // green its own sensor is ignored.
    for (int i = 1; i <= 3; i++) begin
      if (state_q == ALLRED_S && state_d == GREEN_S && int'(next_q) == i)
        pend_d[i] = 1'b0;
      else if (req[i] && !(state_q == GREEN_S && int'(phase_q) == i))
        pend_d[i] = 1'b1;
    end

    timer_clr = rst || (state_d != state_q);
  end

  // Sequencer registers; reset lands directly in MAIN green with no clearance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GREEN_S;
      phase_q <= MAIN;
      next_q  <= MAIN;
      ptr_q   <= TURN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      next_q  <= next_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Lamp decode: lamps shared by both phases stay green, the rest go
  // yellow then red during the handover.
  always_comb begin
    logic [3:0] cur;
    logic [3:0] nxt;
    logic [2:0] lamp [4];
    cur = green_set(phase_q);
    nxt = green_set(next_q);
    for (int i = 0; i < 4; i++) begin
      lamp[i] = RED;
      case (state_q)
        GREEN_S:  lamp[i] = cur[i] ? GREEN : RED;
        YELLOW_S: lamp[i] = (cur[i] && nxt[i]) ? GREEN : (cur[i] ? YELLOW : RED);
        default:  lamp[i] = (cur[i] && nxt[i]) ? GREEN : RED;
      endcase
    end
    m1 = lamp[3];
    m2 = lamp[2];
    mt = lamp[1];
    s  = lamp[0];
  end

  assign walk    = (state_q == GREEN_S) && (phase_q == PED);
  assign ped_ack = walk && (count == '0);
  assign phase   = phase_q;

endmodule
